// File: rtl/demod_pkg.sv
// Shared types for the demodulator sweep logic.
// State encoding and default datapath widths.
package demod_pkg;

  localparam int DEF_WIDTH_AMP  = 10;
  localparam int DEF_WIDTH_STEP = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_REPORT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/amp_averager.sv
// Accumulates 2^AVG_LOG2 amplitude samples.
// full flags that the next strobe completes the window.
module amp_averager
  import demod_pkg::*;
#(
  parameter int WIDTH_AMP = DEF_WIDTH_AMP,
  parameter int AVG_LOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 strobe,
  input  logic [WIDTH_AMP-1:0] amp,
  output logic [WIDTH_AMP-1:0] avg,
  output logic                 full
);

  localparam int AW = WIDTH_AMP + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST =
    CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  // sum and count samples; clear restarts the window
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (strobe) begin
      acc <= acc + AW'(amp);
      cnt <= cnt + 1'b1;
    end
  end

  assign avg  = acc[AW-1:AVG_LOG2];
  assign full = (cnt == LAST);

endmodule

// File: rtl/sweep_controller.sv
// Steps the DDS through a sweep, averaging the
// approximator amplitude at each step and tracking the peak.
module sweep_controller
  import demod_pkg::*;
#(
  parameter int WIDTH_AMP  = DEF_WIDTH_AMP,
  parameter int WIDTH_STEP = DEF_WIDTH_STEP,
  parameter int SETTLE     = 2,
  parameter int AVG_LOG2   = 2,
  parameter int STEP_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH_STEP-1:0] step_first,
  input  logic [WIDTH_STEP-1:0] step_last,
  input  logic [WIDTH_STEP-1:0] step_inc,
  input  logic [WIDTH_AMP-1:0]  amp,
  input  logic                  amp_valid,
  output logic                  adc_go,
  output logic [WIDTH_STEP-1:0] module_step,
  output logic                  busy,
  output logic                  meas_valid,
  output logic [WIDTH_STEP-1:0] meas_step,
  output logic [WIDTH_AMP-1:0]  meas_amp,
  output logic [WIDTH_STEP-1:0] peak_step,
  output logic [WIDTH_AMP-1:0]  peak_amp,
  output logic                  done
);

  localparam int WS = WIDTH_STEP;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(SETTLE - 1);

  state_t          state;
  logic [SW-1:0]   scnt;
  logic [WS-1:0]   last_q;
  logic [WS-1:0]   inc_q;
  logic [WS:0]     next_step;
  logic            stop;
  logic            avg_clear;
  logic            avg_strobe;
  logic            avg_full;
  logic [WIDTH_AMP-1:0] avg;

  // carry bit catches wrap past the top of the step range
  assign next_step = {1'b0, module_step} + {1'b0, inc_q};
  assign stop = (inc_q == '0) || next_step[WS] ||
                (next_step[WS-1:0] > last_q);

  assign avg_strobe = amp_valid && !abort &&
                      (state == ST_ACCUM);
  assign avg_clear  = amp_valid && !abort &&
                      (state == ST_SETTLE) &&
                      (scnt == SETTLE_LAST);

  amp_averager #(
    .WIDTH_AMP (WIDTH_AMP),
    .AVG_LOG2  (AVG_LOG2)
  ) u_avg (
    .clk    (clk),
    .rst    (rst),
    .clear  (avg_clear),
    .strobe (avg_strobe),
    .amp    (amp),
    .avg    (avg),
    .full   (avg_full)
  );

  // sweep sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      module_step <= WS'(STEP_RESET);
      busy        <= 1'b0;
      adc_go      <= 1'b0;
      meas_valid  <= 1'b0;
      meas_step   <= '0;
      meas_amp    <= '0;
      peak_step   <= '0;
      peak_amp    <= '0;
      done        <= 1'b0;
      scnt        <= '0;
      last_q      <= '0;
      inc_q       <= '0;
    end else begin
      meas_valid <= 1'b0;
      done       <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        adc_go <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              module_step <= step_first;
              last_q      <= step_last;
              inc_q       <= step_inc;
              peak_step   <= '0;
              peak_amp    <= '0;
              scnt        <= '0;
              busy        <= 1'b1;
              adc_go      <= 1'b1;
              state       <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (amp_valid) begin
              if (scnt == SETTLE_LAST) begin
                scnt  <= '0;
                state <= ST_ACCUM;
              end else begin
                scnt <= scnt + 1'b1;
              end
            end
          end
          ST_ACCUM: begin
            if (amp_valid && avg_full) begin
              state <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            meas_valid <= 1'b1;
            meas_step  <= module_step;
            meas_amp   <= avg;
            if (avg > peak_amp) begin
              peak_amp  <= avg;
              peak_step <= module_step;
            end
            if (stop) begin
              adc_go <= 1'b0;
              state  <= ST_DONE;
            end else begin
              module_step <= next_step[WS-1:0];
              scnt        <= '0;
              state       <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            done   <= 1'b1;
            busy   <= 1'b0;
            adc_go <= 1'b0;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller: directed sweeps plus random
// sweeps checked against a list-based sweep model.
module tb_sweep_controller;

  localparam int SETTLE_N = 2;
  localparam int N_AVG    = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] step_first;
  logic [7:0] step_last;
  logic [7:0] step_inc;
  logic [9:0] amp;
  logic       amp_valid;
  logic       adc_go;
  logic [7:0] module_step;
  logic       busy;
  logic       meas_valid;
  logic [7:0] meas_step;
  logic [9:0] meas_amp;
  logic [7:0] peak_step;
  logic [9:0] peak_amp;
  logic       done;

  sweep_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .step_first  (step_first),
    .step_last   (step_last),
    .step_inc    (step_inc),
    .amp         (amp),
    .amp_valid   (amp_valid),
    .adc_go      (adc_go),
    .module_step (module_step),
    .busy        (busy),
    .meas_valid  (meas_valid),
    .meas_step   (meas_step),
    .meas_amp    (meas_amp),
    .peak_step   (peak_step),
    .peak_amp    (peak_amp),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // sample table: amplitude sent for k-th strobe at a step
  logic [9:0] val [256][8];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // ADC model: strobes at random; k counts strobes since
  // the step last changed or the sweep began
  int         k = 0;
  logic [7:0] last_seen = 8'd0;
  always @(negedge clk) begin
    if (!busy || module_step != last_seen) k = 0;
    last_seen = module_step;
    if ($urandom_range(0, 1) == 1) begin
      amp_valid = 1'b1;
      if (busy) begin
        amp = val[module_step][(k > 7) ? 7 : k];
        k++;
      end else begin
        amp = 10'($urandom);
      end
    end else begin
      amp_valid = 1'b0;
      amp = 10'($urandom);
    end
  end

  // output monitor, sampled 1ns after the edge
  int         cyc = 0;
  int         meas_cyc = -1;
  int         done_cyc = -1;
  int         n_done = 0;
  logic       done_busy = 1'b0;
  logic [7:0] q_step [$];
  logic [9:0] q_amp  [$];
  always @(posedge clk) begin
    #1;
    cyc++;
    if (meas_valid) begin
      q_step.push_back(meas_step);
      q_amp.push_back(meas_amp);
      meas_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  // reference: list of steps visited and their averages
  int e_step [$];
  int e_amp  [$];
  int e_pk_step;
  int e_pk_amp;

  task automatic build_model(input int first,
                             input int last,
                             input int inc);
    int s;
    int sum;
    e_step.delete();
    e_amp.delete();
    e_pk_step = 0;
    e_pk_amp  = 0;
    s = first;
    forever begin
      sum = 0;
      for (int j = SETTLE_N; j < SETTLE_N + N_AVG; j++)
        sum += int'(val[s][j]);
      e_step.push_back(s);
      e_amp.push_back(sum / N_AVG);
      if (sum / N_AVG > e_pk_amp) begin
        e_pk_amp  = sum / N_AVG;
        e_pk_step = s;
      end
      if (inc == 0 || s + inc > last || s + inc > 255) break;
      s += inc;
    end
  endtask

  task automatic fill_const(input int s, input int v);
    for (int j = 0; j < 8; j++) val[s][j] = 10'(v);
  endtask

  task automatic pulse_start(input int first,
                             input int last,
                             input int inc);
    @(negedge clk);
    step_first = 8'(first);
    step_last  = 8'(last);
    step_inc   = 8'(inc);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    step_first = 8'($urandom);
    step_last  = 8'($urandom);
    step_inc   = 8'($urandom);
  endtask

  task automatic run_sweep(input string tag,
                           input int first,
                           input int last,
                           input int inc,
                           input bit poke);
    int d0;
    build_model(first, last, inc);
    q_step.delete();
    q_amp.delete();
    d0 = n_done;
    pulse_start(first, last, inc);
    for (int t = 0; t < 20000 && n_done == d0; t++) begin
      @(negedge clk);
      start = poke && (t == 10);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, ".done_cnt"}, n_done - d0, 1);
    chk({tag, ".n_meas"}, q_step.size(), e_step.size());
    for (int i = 0; i < e_step.size(); i++) begin
      if (i < q_step.size()) begin
        chk($sformatf("%s.step%0d", tag, i),
            q_step[i], e_step[i]);
        chk($sformatf("%s.amp%0d", tag, i),
            q_amp[i], e_amp[i]);
      end
    end
    chk({tag, ".peak_step"}, peak_step, e_pk_step);
    chk({tag, ".peak_amp"}, peak_amp, e_pk_amp);
    chk({tag, ".mod_step"}, module_step,
        e_step[e_step.size()-1]);
    chk({tag, ".done_lat"}, done_cyc, meas_cyc + 1);
    chk({tag, ".busy_at_done"}, done_busy, 0);
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".adc_go_end"}, adc_go, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mod_step"}, module_step, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".adc_go"}, adc_go, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".meas_valid"}, meas_valid, 0);
    chk({tag, ".meas_amp"}, meas_amp, 0);
    chk({tag, ".peak_amp"}, peak_amp, 0);
    chk({tag, ".peak_step"}, peak_step, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int ok;
    rst        = 1'b1;
    start      = 1'b1;
    abort      = 1'b0;
    step_first = 8'd20;
    step_last  = 8'd30;
    step_inc   = 8'd1;
    for (int s = 0; s < 256; s++) fill_const(s, 0);

    // reset dominates a held start
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.busy", busy, 0);

    // three-step sweep with a clear peak
    fill_const(1, 100);
    fill_const(3, 300);
    fill_const(5, 200);
    run_sweep("sweep135", 1, 5, 2, 1'b0);

    // settle samples discarded, averaging truncates
    val[7][0] = 10'd999;
    val[7][1] = 10'd999;
    val[7][2] = 10'd10;
    val[7][3] = 10'd11;
    val[7][4] = 10'd12;
    val[7][5] = 10'd13;
    val[7][6] = 10'd999;
    val[7][7] = 10'd999;
    run_sweep("avg7", 7, 7, 0, 1'b0);
    chk("avg7.value", meas_amp, 11);

    // overflow of the step must not wrap
    fill_const(250, 123);
    fill_const(4, 555);
    run_sweep("wrap", 250, 255, 10, 1'b0);

    // first beyond last gives one measurement
    fill_const(9, 77);
    run_sweep("rev", 9, 3, 1, 1'b0);

    // abort in the second step's accumulation
    fill_const(1, 400);
    fill_const(2, 900);
    for (int s = 3; s < 10; s++) fill_const(s, s * 10);
    q_step.delete();
    q_amp.delete();
    d0 = n_done;
    pulse_start(1, 9, 1);
    ok = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (module_step == 8'd2 && k >= 3) begin
        ok = 1;
        break;
      end
    end
    chk("abort.reached", ok, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.adc_go", adc_go, 0);
    repeat (20) @(negedge clk);
    chk("abort.no_done", n_done - d0, 0);
    chk("abort.n_meas", q_step.size(), 1);
    chk("abort.peak_step", peak_step, 1);
    chk("abort.peak_amp", peak_amp, 400);
    chk("abort.mod_step", module_step, 2);
    run_sweep("after_abort", 1, 4, 1, 1'b0);

    // ties keep the earlier step; start mid-sweep ignored
    fill_const(2, 50);
    fill_const(3, 50);
    fill_const(4, 40);
    run_sweep("ties", 2, 4, 1, 1'b1);

    // reset during settling
    pulse_start(2, 4, 1);
    repeat (2) @(negedge clk);
    chk("rst_mid.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst_mid");

    // random sweeps
    repeat (6) begin
      int f;
      int l;
      int inc;
      for (int s = 0; s < 256; s++)
        for (int j = 0; j < 8; j++)
          val[s][j] = ($urandom_range(0, 3) == 0) ?
                      10'd500 : 10'($urandom);
      f   = $urandom_range(0, 255);
      l   = $urandom_range(0, 255);
      inc = ($urandom_range(0, 4) == 0) ?
            0 : $urandom_range(4, 64);
      run_sweep($sformatf("rnd_%0d_%0d_%0d", f, l, inc),
                f, l, inc, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
Sequences the demodulator chain (ADC control, DDS generator, approximator) through a frequency sweep of DDS step values. For each step it holds module_step, discards a settling number of amplitude results, then averages 2^AVG_LOG2 results. It reports one measurement per step and tracks the step with the peak amplitude. It sits above adc_control and dds_generator and replaces manual testbench stepping of modul_step.

Parameters:
WIDTH_AMP, 10, width of approximator amplitude input
WIDTH_STEP, 8, width of DDS module_step
SETTLE, 2, amp_valid strobes discarded after every step change (>=1)
AVG_LOG2, 2, log2 of the number of averaged samples per step
STEP_RESET, 1, module_step value after reset

Ports:
clk  in  1  system clock (same clock as adc_control/approximator)
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle sweep request; ignored while busy
abort  in  1  terminate the sweep immediately
step_first  in  WIDTH_STEP  first step; latched on accepted start
step_last  in  WIDTH_STEP  last step, inclusive; latched on start
step_inc  in  WIDTH_STEP  step increment; latched on start
amp  in  WIDTH_AMP  approximator amplitude
amp_valid  in  1  one-cycle strobe: amp holds a new result
adc_go  out  1  enable to adc_control iGO
module_step  out  WIDTH_STEP  DDS step; changes only between measurements
busy  out  1  sweep in progress
meas_valid  out  1  one-cycle strobe: meas_step/meas_amp updated
meas_step  out  WIDTH_STEP  step of the reported measurement
meas_amp  out  WIDTH_AMP  averaged amplitude
peak_step  out  WIDTH_STEP  step of the maximum meas_amp in the current sweep
peak_amp  out  WIDTH_AMP  maximum meas_amp in the current sweep
done  out  1  one-cycle strobe at normal sweep completion

Behaviour:
- Reset values: module_step=STEP_RESET. All other outputs 0. State=IDLE. Reset has priority over abort and start.
- Accumulator width is WIDTH_AMP+AVG_LOG2. meas_amp = acc >> AVG_LOG2 (truncating). No overflow is possible.
- FSM states: IDLE, SETTLE, ACCUM, REPORT, DONE.
- IDLE: busy=0, adc_go=0. On start, latch first/last/inc, set module_step=step_first, clear peak_amp/peak_step and counters, then go to SETTLE.
- SETTLE: busy=1, adc_go=1. Count amp_valid strobes. On the SETTLE-th strobe, clear acc and go to ACCUM. amp values are ignored in this state.
- ACCUM: on each amp_valid, acc+=amp. On the 2^AVG_LOG2-th strobe, go to REPORT.
- REPORT (exactly 1 cycle): the outputs meas_valid=1, meas_step=module_step and meas_amp=average are registered. They become visible one clock after the edge that accepted the final sample.
- Peak update in REPORT: if meas_amp > peak_amp (strict), update peak_amp and peak_step. Ties keep the earlier step. The first step always updates the peak unless its average is 0.
- Next-step decision in REPORT: compute next = module_step+step_inc at WIDTH_STEP+1 bits. If step_inc==0, or next > step_last, or next overflows, go to DONE. Otherwise set module_step=next and go to SETTLE.
- step_first > step_last produces a single measurement at step_first, then DONE.
- DONE: done=1 for 1 cycle, adc_go=0, then IDLE. busy drops in the same cycle as done. module_step holds its last value.
- abort in any non-IDLE state goes to IDLE on the next edge. busy, adc_go and the strobes are 0; no done and no meas_valid are issued. peak registers and module_step hold their values.
- abort wins over a simultaneous amp_valid. start in the same cycle as abort is ignored.
- amp_valid in IDLE or DONE is ignored.
- module_step crosses into the DDS clock domain as a quasi-static bus. It is stable for at least SETTLE ADC conversions before any sample is used.

Decomposition:
- Package demod_pkg: state enum (IDLE, SETTLE, ACCUM, REPORT, DONE), default widths WIDTH_AMP and WIDTH_STEP.
- One sub-module, amp_averager: accumulator plus sample counter and the shift, with clear/strobe inputs and a full flag.

Test Plan:
1. Reset: assert rst for 3 cycles while start=1 -> module_step=1, busy/adc_go/done/meas_valid=0, peak_amp=0.
2. Sweep first=1, last=5, inc=2; bench drives amp=100/300/200 for steps 1/3/5 -> three meas_valid pulses (1,100), (3,300), (5,200); peak_step=3, peak_amp=300; one done pulse; module_step ends at 5.
3. Averaging at step 7, inc=0: samples 999, 999 (discarded), then 10, 11, 12, 13 -> meas_amp=11; done one cycle after meas_valid.
4. Wrap and limits: first=250, last=255, inc=10 -> one measurement at 250, then done, no wrap to 4. Separately, first=9, last=3 -> one measurement at 9.
5. Abort mid-ACCUM of the second step -> busy=0 and adc_go=0 after one edge, no done, peak holds step-1 values. A following start then runs a full sweep correctly.
6. Ties and ignored start: amps 50, 50, 40 over steps 2, 3, 4 -> peak_step=2. A start pulse during the sweep changes nothing. rst mid-SETTLE returns all outputs to reset values.
